// File: rtl/vga_sdram_arbiter_pkg.sv
// rtl/vga_sdram_arbiter_pkg.sv - shared types and default widths for the VGA/SDRAM arbiter
package vga_sdram_arb_pkg;

   localparam int DEF_ADDR_W       = 25;
   localparam int DEF_DATA_W       = 16;
   localparam int DEF_BURST_W      = 8;
   localparam int DEF_MAX_BURST    = 128;
   localparam int DEF_STARVE_LIMIT = 1024;

   typedef enum logic [1:0] {
      IDLE,
      RD_CMD,
      RD_DATA,
      WR_BURST
   } arb_state_t;

   typedef enum logic {
      REQ_RD,
      REQ_WR
   } requester_t;

endpackage

// File: rtl/arb_rr_starve.sv
// rtl/arb_rr_starve.sv - two-way urgent/round-robin choice with a bounded writer wait
module arb_rr_starve
   import vga_sdram_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       arb_en,
   input  logic       rd_req,
   input  logic       rd_urgent,
   input  logic       wr_req,
   output logic       win_valid,
   output requester_t win_who
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;
   requester_t       last_grant;
   logic             starved;
   logic             wr_won;

   assign starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));
   assign wr_won  = win_valid && (win_who == REQ_WR);

   always_comb begin
      win_valid = 1'b0;
      win_who   = REQ_RD;
      if (arb_en && (rd_req || wr_req)) begin
         win_valid = 1'b1;
         if (rd_req && wr_req) begin
            if (starved)
               win_who = REQ_WR;
            else if (rd_urgent)
               win_who = REQ_RD;
            else
               win_who = (last_grant == REQ_WR) ? REQ_RD : REQ_WR;
         end else begin
            win_who = wr_req ? REQ_WR : REQ_RD;
         end
      end
   end

   // The counter saturates at the limit; only the >= comparison matters beyond it.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
         last_grant <= REQ_WR;
      end else begin
         if (win_valid)
            last_grant <= win_who;
         if (!wr_req || wr_won)
            starve_cnt <= '0;
         else if (!starved)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_sdram_arbiter.sv
// rtl/vga_sdram_arbiter.sv - shares one Avalon-MM SDRAM master between scan-out reads and frame writes
module vga_sdram_arbiter
   import vga_sdram_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int BURST_W      = DEF_BURST_W,
   parameter int MAX_BURST    = DEF_MAX_BURST,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rd_req,
   input  logic               rd_urgent,
   input  logic [ADDR_W-1:0]  rd_addr,
   input  logic [BURST_W-1:0] rd_len,
   output logic               rd_grant,
   output logic [DATA_W-1:0]  rd_data,
   output logic               rd_data_valid,
   input  logic               wr_req,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [BURST_W-1:0] wr_len,
   output logic               wr_grant,
   input  logic [DATA_W-1:0]  wr_data,
   output logic               wr_data_ack,
   output logic [ADDR_W-1:0]  avm_address,
   output logic               avm_read,
   output logic               avm_write,
   output logic [BURST_W-1:0] avm_burstcount,
   output logic [DATA_W-1:0]  avm_writedata,
   input  logic               avm_waitrequest,
   input  logic [DATA_W-1:0]  avm_readdata,
   input  logic               avm_readdatavalid,
   output logic               busy
);

   localparam logic [BURST_W-1:0] MAX_LEN = BURST_W'(MAX_BURST);
   localparam logic [BURST_W-1:0] ONE     = BURST_W'(1);

   arb_state_t         state;
   logic [BURST_W-1:0] beat_cnt;
   logic [BURST_W-1:0] rd_len_c;
   logic [BURST_W-1:0] wr_len_c;
   logic               win_valid;
   requester_t         win_who;
   logic               arb_en;
   logic               rd_beat;

   // Grants are combinational so the requester's address/length are captured in the grant cycle.
   assign arb_en   = (state == IDLE) && !reset;
   assign rd_grant = win_valid && (win_who == REQ_RD);
   assign wr_grant = win_valid && (win_who == REQ_WR);

   assign rd_len_c = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;
   assign wr_len_c = (wr_len > MAX_LEN) ? MAX_LEN : wr_len;

   assign busy          = (state != IDLE);
   assign avm_writedata = avm_write ? wr_data : '0;
   assign wr_data_ack   = avm_write & ~avm_waitrequest;

   // Beats seen outside RD_DATA (e.g. left over from an aborted burst) are dropped here.
   assign rd_beat = (state == RD_DATA) && avm_readdatavalid;

   arb_rr_starve #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .arb_en    (arb_en),
      .rd_req    (rd_req),
      .rd_urgent (rd_urgent),
      .wr_req    (wr_req),
      .win_valid (win_valid),
      .win_who   (win_who)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         beat_cnt       <= '0;
         avm_address    <= '0;
         avm_burstcount <= '0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         rd_data        <= '0;
         rd_data_valid  <= 1'b0;
      end else begin
         rd_data_valid <= rd_beat;
         if (rd_beat)
            rd_data <= avm_readdata;

         case (state)
            IDLE: begin
               // A zero-length grant is acknowledged but issues nothing on the bus.
               if (rd_grant && (rd_len_c != '0)) begin
                  state          <= RD_CMD;
                  avm_read       <= 1'b1;
                  avm_address    <= rd_addr;
                  avm_burstcount <= rd_len_c;
                  beat_cnt       <= rd_len_c;
               end else if (wr_grant && (wr_len_c != '0)) begin
                  state          <= WR_BURST;
                  avm_write      <= 1'b1;
                  avm_address    <= wr_addr;
                  avm_burstcount <= wr_len_c;
                  beat_cnt       <= wr_len_c;
               end
            end
            RD_CMD: begin
               if (!avm_waitrequest) begin
                  avm_read <= 1'b0;
                  state    <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (avm_readdatavalid) begin
                  beat_cnt <= beat_cnt - ONE;
                  if (beat_cnt == ONE)
                     state <= IDLE;
               end
            end
            WR_BURST: begin
               if (!avm_waitrequest) begin
                  beat_cnt <= beat_cnt - ONE;
                  if (beat_cnt == ONE) begin
                     avm_write <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sdram_arbiter.sv
// tb/tb_vga_sdram_arbiter.sv - randomized scoreboard bench for vga_sdram_arbiter
module tb_vga_sdram_arbiter;

   localparam int ADDR_W       = 25;
   localparam int DATA_W       = 16;
   localparam int BURST_W      = 8;
   localparam int MAX_BURST    = 128;
   localparam int STARVE_LIMIT = 16;
   localparam int WS_N         = 8192;

   logic               clk = 1'b0;
   logic               reset;
   logic               rd_req, rd_urgent, wr_req;
   logic [ADDR_W-1:0]  rd_addr, wr_addr;
   logic [BURST_W-1:0] rd_len, wr_len;
   logic               rd_grant, wr_grant, rd_data_valid, wr_data_ack, busy;
   logic [DATA_W-1:0]  rd_data, wr_data, avm_writedata, avm_readdata;
   logic [ADDR_W-1:0]  avm_address;
   logic               avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
   logic [BURST_W-1:0] avm_burstcount;

   always #5 clk = ~clk;

   vga_sdram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
      .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_urgent(rd_urgent), .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_grant(rd_grant), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_grant(wr_grant),
      .wr_data(wr_data), .wr_data_ack(wr_data_ack),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   typedef struct { int who; logic [ADDR_W-1:0] addr; int len; } cmd_t;
   typedef struct { logic [ADDR_W-1:0] addr; int len; logic [DATA_W-1:0] data; } wbeat_t;

   cmd_t              exp_grant_q[$];
   cmd_t              exp_rdcmd_q[$];
   wbeat_t            exp_wbeat_q[$];
   logic [DATA_W-1:0] exp_rdata_q[$];

   logic [DATA_W-1:0] wstream [WS_N];
   int wptr = 0;

   // Reference model: one outstanding burst, described by who owns the bus and beats left.
   logic              m_busy = 1'b0, m_busy_now = 1'b0, m_is_wr = 1'b0, m_cmd_done = 1'b0;
   logic              flush_req = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0, m_gaddr;
   int                m_len = 0, m_rem = 0, m_starve = 0, m_last = 1, m_widx = 0;
   int                m_who, m_glen;

   always @(negedge clk) begin
      m_busy_now = m_busy;
      if (reset) begin
         m_busy = 1'b0; m_starve = 0; m_last = 1; flush_req = 1'b1;
      end else begin
         m_who = -1;
         if (!m_busy) begin
            if (rd_req && wr_req)
               m_who = (m_starve >= STARVE_LIMIT) ? 1 : (rd_urgent ? 0 : (m_last == 1 ? 0 : 1));
            else if (rd_req) m_who = 0;
            else if (wr_req) m_who = 1;
         end
         if (m_who >= 0) begin
            m_glen  = (m_who == 1) ? int'(wr_len) : int'(rd_len);
            if (m_glen > MAX_BURST) m_glen = MAX_BURST;
            m_gaddr = (m_who == 1) ? wr_addr : rd_addr;
            exp_grant_q.push_back('{m_who, m_gaddr, m_glen});
            m_last = m_who;
            if (m_glen != 0) begin
               m_busy = 1'b1; m_is_wr = (m_who == 1); m_addr = m_gaddr;
               m_len = m_glen; m_rem = m_glen; m_cmd_done = 1'b0;
               if (m_who == 0) exp_rdcmd_q.push_back('{0, m_gaddr, m_glen});
            end
         end else if (m_busy) begin
            if (m_is_wr) begin
               if (!avm_waitrequest) begin
                  exp_wbeat_q.push_back('{m_addr, m_len, wstream[m_widx % WS_N]});
                  m_widx++; m_rem--;
                  if (m_rem == 0) m_busy = 1'b0;
               end
            end else if (!m_cmd_done) begin
               if (!avm_waitrequest) m_cmd_done = 1'b1;
            end else if (avm_readdatavalid) begin
               exp_rdata_q.push_back(avm_readdata);
               m_rem--;
               if (m_rem == 0) m_busy = 1'b0;
            end
         end
         if (wr_req && m_who != 1) begin
            if (m_starve < STARVE_LIMIT) m_starve++;
         end else begin
            m_starve = 0;
         end
      end
   end

   // Monitor: pops an expectation whenever the DUT presents an output event.
   cmd_t   mon_c;
   wbeat_t mon_w;
   always @(negedge clk) begin
      #1;
      check("busy", busy, m_busy_now);
      check("rw_exclusive", avm_read & avm_write, 0);
      if (rd_grant || wr_grant) begin
         check("grant_onehot", rd_grant & wr_grant, 0);
         check("grant_expected", exp_grant_q.size() != 0, 1);
         if (exp_grant_q.size() != 0) begin
            mon_c = exp_grant_q.pop_front();
            check("grant_who", wr_grant, mon_c.who);
         end
      end
      if (avm_read && !avm_waitrequest) begin
         check("rdcmd_expected", exp_rdcmd_q.size() != 0, 1);
         if (exp_rdcmd_q.size() != 0) begin
            mon_c = exp_rdcmd_q.pop_front();
            check("rdcmd_addr", avm_address, mon_c.addr);
            check("rdcmd_burstcount", avm_burstcount, mon_c.len);
         end
      end
      if (wr_data_ack) begin
         check("wbeat_expected", exp_wbeat_q.size() != 0, 1);
         if (exp_wbeat_q.size() != 0) begin
            mon_w = exp_wbeat_q.pop_front();
            check("wbeat_data", avm_writedata, mon_w.data);
            check("wbeat_addr", avm_address, mon_w.addr);
            check("wbeat_burstcount", avm_burstcount, mon_w.len);
         end
      end
      if (rd_data_valid) begin
         check("rdata_expected", exp_rdata_q.size() != 0, 1);
         if (exp_rdata_q.size() != 0)
            check("rdata_value", rd_data, exp_rdata_q.pop_front());
      end
      if (flush_req) begin
         exp_grant_q.delete(); exp_rdcmd_q.delete();
         exp_wbeat_q.delete(); exp_rdata_q.delete();
         flush_req = 1'b0;
      end
   end

   // SDRAM slave stand-in and requester handshakes, advanced one clock per call.
   int sl_pending = 0, sl_delay = 0, sl_driven = 0, wait_pct = 0;
   logic sl_always = 1'b0;

   task automatic step();
      logic rg, wg, ack, racc;
      int   bc;
      @(negedge clk);
      rg = rd_grant; wg = wr_grant; ack = wr_data_ack;
      racc = avm_read & ~avm_waitrequest; bc = int'(avm_burstcount);
      @(posedge clk);
      #1;
      if (rg) rd_req = 1'b0;
      if (wg) wr_req = 1'b0;
      if (ack) wptr++;
      wr_data = wstream[wptr % WS_N];
      if (racc) begin sl_pending += bc; sl_delay = 2; end
      if (sl_delay > 0) begin
         sl_delay--; avm_readdatavalid = 1'b0;
      end else if (sl_pending > 0 && (sl_always || ($urandom % 4) != 0)) begin
         avm_readdatavalid = 1'b1; avm_readdata = DATA_W'($urandom);
         sl_pending--; sl_driven++;
      end else begin
         avm_readdatavalid = 1'b0;
      end
      avm_waitrequest = int'($urandom % 100) < wait_pct;
   endtask

   task automatic wait_idle();
      logic idle;
      idle = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         idle = !rd_req && !wr_req && !m_busy && sl_pending == 0 && sl_delay == 0;
         if (idle) break;
         step();
      end
      check("idle_reached", idle, 1);
   endtask

   function automatic logic [BURST_W-1:0] rand_len();
      int r;
      r = int'($urandom % 16);
      if (r == 0) return '0;
      if (r == 1) return BURST_W'(129 + ($urandom % 127));
      return BURST_W'(1 + ($urandom % 12));
   endfunction

   task automatic hold_both(input int n, input logic urg);
      rd_urgent = urg;
      for (int i = 0; i < n; i++) begin
         if (!rd_req) begin rd_req = 1'b1; rd_addr = ADDR_W'($urandom); rd_len = 2; end
         if (!wr_req) begin wr_req = 1'b1; wr_addr = ADDR_W'($urandom); wr_len = 2; end
         step();
      end
      rd_req = 1'b0; wr_req = 1'b0;
      wait_idle();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stray;
      for (int i = 0; i < WS_N; i++) wstream[i] = DATA_W'($urandom);
      reset = 1'b1; rd_req = 0; rd_urgent = 0; wr_req = 0;
      rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
      wr_data = wstream[0]; avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_avm_read", avm_read, 0);
      check("rst_avm_write", avm_write, 0);
      check("rst_rd_data_valid", rd_data_valid, 0);
      check("rst_burstcount", avm_burstcount, 0);
      check("rst_address", avm_address, 0);
      check("rst_rd_grant", rd_grant, 0);
      reset = 1'b0;

      // Contended start: reader wins first, then the 8-beat write.
      wait_pct = 30;
      rd_req = 1; rd_addr = 'h100; rd_len = 4; wr_req = 1; wr_addr = 'h2000; wr_len = 8;
      #1;
      check("first_contended_rd", rd_grant, 1);
      wait_idle();

      // Zero-length read, then an immediate follow-up request.
      rd_req = 1; rd_addr = 'h40; rd_len = 0;
      step();
      check("zero_len_no_read", avm_read, 0);
      rd_req = 1; rd_addr = 'h80; rd_len = 3;
      #1;
      check("zero_len_next_grant", rd_grant, 1);
      wait_idle();

      wr_req = 1; wr_addr = 'h3000; wr_len = 200;
      wait_idle();

      hold_both(60, 1'b0);
      hold_both(150, 1'b1);

      wait_pct = 25;
      for (int i = 0; i < 2500; i++) begin
         rd_urgent = ($urandom % 4) == 0;
         if (!rd_req && ($urandom % 3) == 0) begin
            rd_req = 1; rd_addr = ADDR_W'($urandom); rd_len = rand_len();
         end
         if (!wr_req && ($urandom % 3) == 0) begin
            wr_req = 1; wr_addr = ADDR_W'($urandom); wr_len = rand_len();
         end
         step();
      end
      rd_req = 0; wr_req = 0;
      wait_idle();

      // Reset during RD_DATA after two of eight beats; the remaining six must vanish.
      wait_pct = 0; sl_always = 1; sl_driven = 0;
      rd_req = 1; rd_addr = 'h555; rd_len = 8; rd_urgent = 0;
      for (int i = 0; i < 50 && sl_driven < 2; i++) step();
      check("reset_test_two_beats", sl_driven, 2);
      step();
      reset = 1;
      step();
      reset = 0;
      check("post_reset_busy", busy, 0);
      check("post_reset_avm_read", avm_read, 0);
      check("post_reset_valid", rd_data_valid, 0);
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         stray += int'(rd_data_valid);
      end
      check("stray_beats_drained", sl_pending, 0);
      check("stray_rd_data_valid", stray, 0);
      sl_always = 0;

      // After reset the round-robin pointer again favours the reader.
      wait_pct = 20;
      rd_req = 1; rd_addr = 'h777; rd_len = 2; wr_req = 1; wr_addr = 'h888; wr_len = 3;
      #1;
      check("post_reset_contended_rd", rd_grant, 1);
      wait_idle();

      repeat (4) step();
      check("end_grant_q_empty", exp_grant_q.size(), 0);
      check("end_rdcmd_q_empty", exp_rdcmd_q.size(), 0);
      check("end_wbeat_q_empty", exp_wbeat_q.size(), 0);
      check("end_rdata_q_empty", exp_rdata_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
